bd4_channel_tx: RTL and testbench
=================================

Name: bd4_channel_tx

Overview:
Clocked transmitter that drives one 4-phase (return-to-zero) bundled-data channel into the asynchronous spiking-CNN pipeline.
- Accepts words from the synchronous domain on a valid/ready interface and buffers them in a small FIFO.
- Issues each word as rdata/rreq and completes the full req/ack cycle against the first asynchronous controller stage.
- Sits at the sync-to-async boundary of each mesh NoC injection port.

Parameters:
WIDTH, 8, data/flit width in bits
DEPTH, 4, FIFO entries (power of two, >=2)
SETUP_CYCLES, 1, clock cycles rdata is stable before rreq rises (bundling margin, >=1)
SYNC_STAGES, 2, flops in the rack synchronizer (>=2)
TIMEOUT_CYCLES, 1024, ack watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  sync-side word valid
in_ready  out  1  sync-side ready (= FIFO not full)
in_data  in  WIDTH  sync-side word
rreq  out  1  4-phase request, registered, glitch-free
rack  in  1  4-phase acknowledge, asynchronous
rdata  out  WIDTH  bundled data, registered
busy  out  1  FSM not in IDLE or FIFO non-empty
level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values: rreq=0, rdata=0, busy=0, level=0, in_ready=1 from the first edge after rst is sampled high. FIFO pointers are cleared and the FSM goes to IDLE.
- rack passes through SYNC_STAGES flops to give ack_s. The FSM uses only ack_s.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = !full. It depends on occupancy only, so a same-cycle pop does not allow a push into a full FIFO.
  - Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
  - IDLE: if FIFO non-empty and ack_s==0, pop the head into the rdata register, load the counter with SETUP_CYCLES, go to SETUP. If ack_s==1, stay in IDLE; this guards against a stale ack after a reset.
  - SETUP: decrement the counter. When it reaches 0, set rreq=1 and go to REQ_HI.
  - REQ_HI: wait for ack_s==1, then set rreq=0 and go to REQ_LO.
  - REQ_LO: wait for ack_s==0, then go to IDLE. The back-to-back IDLE pop happens on the next cycle.
- rdata is held constant from the SETUP load until the exit from REQ_LO. It never changes while rreq=1 or while ack_s=1.
- Latency, empty FIFO, DEPTH>=2:
  - Word pushed at edge t.
  - rdata valid at edge t+1.
  - rreq rises at edge t+1+SETUP_CYCLES.
- Throughput: at most one word per (3 + SETUP_CYCLES + 2*SYNC_STAGES + async response) cycles.
- Reset mid-transfer:
  - rreq drops to 0 at the next edge and the in-flight word is discarded.
  - The FSM will not start a new transfer until ack_s==0.
- rack toggling outside REQ_HI/REQ_LO is ignored. It never creates a transfer.

Optional Feature:
Macro: BD4_TX_ACK_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, reset 0) and a watchdog counter.
  - The counter clears on every state change and increments while in REQ_HI or REQ_LO.
  - When it reaches TIMEOUT_CYCLES, timeout_err sets sticky high and rreq is forced to 0.
  - The FSM then waits in REQ_LO for ack_s==0 as normal.
  - timeout_err clears only on rst.
- Undefined: no port, no counter; the FSM waits indefinitely.

Decomposition:
- Package bd4_pkg holds:
  - the typedef enum logic [1:0] for the FSM states {IDLE, SETUP, REQ_HI, REQ_LO};
  - the default WIDTH/DEPTH localparams;
  - a function computing the occupancy width.
- One sub-module is natural: bd4_sync_fifo, the parameterised synchronous FIFO with push/pop/full/empty/level.
- The rack synchronizer stays inline.

Test Plan:
1. Reset then push 0xA5 with an async model that acks 3 cycles after rreq and deasserts ack 3 cycles after rreq falls (SETUP_CYCLES=1, SYNC_STAGES=2) -> rdata=0xA5 at t+1, rreq=1 at t+2, held until ack_s rises, exactly one 4-phase cycle, busy returns to 0.
2. Burst push 0x01..0x06 into DEPTH=4 with a slow ack -> in_ready=0 once level=4; words appear on rdata in order 01..06 with none lost or duplicated; rdata is never observed changing while rreq=1 or ack_s=1.
3. Full FIFO with a pop and in_valid in the same cycle -> no push accepted that cycle; level goes 4->3.
4. Assert rst while in REQ_HI with rack still high -> rreq=0 next edge and level=0; after reset release with rack held high for 10 cycles, rreq stays 0; the transfer starts only after rack falls.
5. Spurious rack pulse while in IDLE with the FIFO empty -> no rreq and no state change.
6. With BD4_TX_ACK_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, rack never asserted -> timeout_err=1 sixteen cycles after entering REQ_HI, rreq forced to 0, and the flag is sticky until rst.

Source files
------------

// File: rtl/bd4_pkg.sv
// bd4_pkg: shared FSM state type, default sizes and occupancy-width helper
// for the 4-phase bundled-data channel transmitter.
package bd4_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} bd4_state_t;

   localparam int BD4_WIDTH = 8;
   localparam int BD4_DEPTH = 4;

   function automatic int bd4_lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/bd4_sync_fifo.sv
// bd4_sync_fifo: power-of-two synchronous FIFO with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module bd4_sync_fifo
   import bd4_pkg::*;
#(
   parameter int WIDTH = BD4_WIDTH,
   parameter int DEPTH = BD4_DEPTH
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic [WIDTH-1:0]              i_data,
   output logic [WIDTH-1:0]              o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [bd4_lvl_w(DEPTH)-1:0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = bd4_lvl_w(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == FULL_LVL);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rp];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/bd4_channel_tx.sv
// bd4_channel_tx: sync-to-async 4-phase bundled-data transmitter.
// Define BD4_TX_ACK_TIMEOUT_EN to add the ack watchdog and timeout_err.
module bd4_channel_tx
   import bd4_pkg::*;
#(
   parameter int WIDTH        = BD4_WIDTH,
   parameter int DEPTH        = BD4_DEPTH,
   parameter int SETUP_CYCLES = 1,
   parameter int SYNC_STAGES  = 2
`ifdef BD4_TX_ACK_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1024
`endif
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        rreq,
   input  logic                        rack,
   output logic [WIDTH-1:0]            rdata,
   output logic                        busy,
   output logic [bd4_lvl_w(DEPTH)-1:0] level
`ifdef BD4_TX_ACK_TIMEOUT_EN
  ,output logic                        timeout_err
`endif
);

   localparam int CW = $clog2(SETUP_CYCLES + 1);

   bd4_state_t             r_state;
   logic [CW-1:0]          r_cnt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_ack_s;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic [WIDTH-1:0]       w_head;

`ifdef BD4_TX_ACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_wd;
   logic          w_wd_hit;
   assign w_wd_hit = (r_wd == TW'(TIMEOUT_CYCLES - 1));
`endif

   // Synchronizer is left unreset so a stale ack stays visible after rst.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rack};
   end

   assign w_ack_s  = r_sync[SYNC_STAGES-1];
   assign w_pop    = (r_state == IDLE) & ~w_empty & ~w_ack_s;
   assign in_ready = ~w_full;
   assign busy     = (r_state != IDLE) | ~w_empty;

   bd4_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_valid),
      .i_pop   (w_pop),
      .i_data  (in_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         rreq    <= 1'b0;
         rdata   <= '0;
`ifdef BD4_TX_ACK_TIMEOUT_EN
         r_wd        <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
`ifdef BD4_TX_ACK_TIMEOUT_EN
         r_wd <= '0;
`endif
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  rdata   <= w_head;
                  r_cnt   <= CW'(SETUP_CYCLES);
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  rreq    <= 1'b1;
                  r_state <= REQ_HI;
               end
            end
            REQ_HI: begin
               if (w_ack_s) begin
                  rreq    <= 1'b0;
                  r_state <= REQ_LO;
               end
`ifdef BD4_TX_ACK_TIMEOUT_EN
               else if (w_wd_hit) begin
                  timeout_err <= 1'b1;
                  rreq        <= 1'b0;
                  r_state     <= REQ_LO;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
`endif
            end
            REQ_LO: begin
               if (!w_ack_s) begin
                  r_state <= IDLE;
               end
`ifdef BD4_TX_ACK_TIMEOUT_EN
               else if (w_wd_hit) begin
                  timeout_err <= 1'b1;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bd4_channel_tx.sv
// tb_bd4_channel_tx: directed bench for bd4_channel_tx with a transfer-level
// reference model, an async ack responder and per-cycle output comparison.
module tb_bd4_channel_tx;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int SC = 1;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       rack;
   logic       in_ready;
   logic       rreq;
   logic [7:0] rdata;
   logic       busy;
   logic [2:0] level;
`ifdef BD4_TX_ACK_TIMEOUT_EN
   logic       timeout_err;
`endif

   always #5 clk = ~clk;

   bd4_channel_tx #(
      .WIDTH        (W),
      .DEPTH        (D),
      .SETUP_CYCLES (SC),
      .SYNC_STAGES  (2)
`ifdef BD4_TX_ACK_TIMEOUT_EN
     ,.TIMEOUT_CYCLES (TO)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .rreq     (rreq),
      .rack     (rack),
      .rdata    (rdata),
      .busy     (busy),
      .level    (level)
`ifdef BD4_TX_ACK_TIMEOUT_EN
     ,.timeout_err (timeout_err)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Async far-end stage: follows rreq after ack_dly cycles when enabled.
   bit   auto_ack = 0;
   int   ack_dly  = 3;
   int   acnt     = 0;
   logic auto_rack = 1'b0;
   logic man_rack  = 1'b0;
   assign rack = auto_ack ? auto_rack : man_rack;

   always @(negedge clk) begin
      if (!auto_ack) begin
         auto_rack = man_rack;
         acnt = 0;
      end else if (auto_rack != rreq) begin
         acnt++;
         if (acnt >= ack_dly) begin
            auto_rack = rreq;
            acnt = 0;
         end
      end else begin
         acnt = 0;
      end
   end

   // Reference model: word queue plus handshake phase, stepped per edge.
   logic [7:0] mq[$];
   logic [7:0] seen[$];
   logic       rk[$] = '{1'b0, 1'b0};
   int         ph = 0;
   int         m_cnt = 0;
   int         m_age = 0;
   logic [7:0] m_rdata = '0;
   logic       m_rreq = 1'b0;
   logic       m_err = 1'b0;
   bit         m_live = 0;
   logic       p_rreq = 1'b0;
   logic [7:0] p_rdata = '0;

   always @(posedge clk) begin
      logic       as;
      logic       was_rst;
      int         pre;
      as = rk[0];
      void'(rk.pop_front());
      rk.push_back(rack);
      pre = mq.size();
      was_rst = rst;
      if (rst) begin
         mq.delete();
         ph = 0;
         m_rdata = '0;
         m_rreq = 1'b0;
         m_err = 1'b0;
         m_live = 1;
      end else begin
         case (ph)
            0: if (pre > 0 && !as) begin
               m_rdata = mq.pop_front();
               m_cnt = SC;
               ph = 1;
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_rreq = 1'b1;
                  ph = 2;
                  m_age = 0;
               end
            end
            2: if (as) begin
               m_rreq = 1'b0;
               ph = 3;
               m_age = 0;
            end else begin
`ifdef BD4_TX_ACK_TIMEOUT_EN
               m_age++;
               if (m_age == TO) begin
                  m_err = 1'b1;
                  m_rreq = 1'b0;
                  ph = 3;
                  m_age = 0;
               end
`endif
            end
            default: if (!as) begin
               ph = 0;
            end else begin
`ifdef BD4_TX_ACK_TIMEOUT_EN
               m_age++;
               if (m_age == TO) begin
                  m_err = 1'b1;
                  m_age = 0;
               end
`endif
            end
         endcase
         if (in_valid && pre < D) mq.push_back(in_data);
      end
      #1;
      if (m_live) begin
         chk("level", 32'(level), 32'(mq.size()));
         chk("in_ready", 32'(in_ready), 32'(mq.size() < D));
         chk("rreq", 32'(rreq), 32'(m_rreq));
         chk("rdata", 32'(rdata), 32'(m_rdata));
         chk("busy", 32'(busy), 32'(ph != 0 || mq.size() != 0));
`ifdef BD4_TX_ACK_TIMEOUT_EN
         chk("timeout_err", 32'(timeout_err), 32'(m_err));
`endif
         if (p_rreq && !was_rst) chk("rdata_hold", 32'(rdata), 32'(p_rdata));
         if (!p_rreq && rreq) seen.push_back(rdata);
         p_rreq = rreq;
         p_rdata = rdata;
      end
   end

   task automatic push(input logic [7:0] d, output int stalls);
      stalls = 0;
      in_valid = 1'b1;
      in_data = d;
      while (!in_ready && stalls < 400) begin
         @(negedge clk);
         stalls++;
      end
      chk("push_accept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rreq(input logic v, input int max, input string nm);
      int n = 0;
      while (rreq !== v && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(rreq), 32'(v));
   endtask

   task automatic wait_idle(input int max, input string nm);
      int n = 0;
      while ((busy !== 1'b0 || rreq !== 1'b0) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   initial begin
      int st;
      int tot;
      int base;
      logic [7:0] exp3 [6];
      exp3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};

      repeat (3) @(negedge clk);
      chk("rst_rreq", 32'(rreq), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single word, 3-cycle async response
      auto_ack = 1;
      ack_dly = 3;
      base = seen.size();
      in_valid = 1'b1;
      in_data = 8'hA5;
      @(posedge clk);
      #1 chk("t0_level", 32'(level), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1 chk("t1_rdata", 32'(rdata), 32'hA5);
      chk("t1_rreq", 32'(rreq), 32'd0);
      @(posedge clk);
      #1 chk("t2_rreq", 32'(rreq), 32'd1);
      @(negedge clk);
      wait_rreq(1'b0, 60, "single_rreq_fall");
      wait_idle(60, "single_idle");
      chk("single_one_cycle", 32'(seen.size() - base), 32'd1);

      // burst through a slow ack
      ack_dly = 8;
      base = seen.size();
      tot = 0;
      for (int i = 1; i <= 6; i++) begin
         push(8'(i), st);
         tot += st;
      end
      chk("burst_stalled", 32'(tot > 0), 32'd1);
      wait_idle(600, "burst_idle");
      chk("burst_count", 32'(seen.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
         if (base + i < seen.size())
            chk("burst_order", 32'(seen[base+i]), 32'(i + 1));

      // full FIFO: pop and in_valid in the same cycle
      auto_ack = 0;
      man_rack = 1'b0;
      @(negedge clk);
      base = seen.size();
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), st);
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data = 8'h77;
      man_rack = 1'b1;
      wait_rreq(1'b0, 20, "full_rreq_fall");
      man_rack = 1'b0;
      for (int n = 0; n < 20 && level == 3'd4; n++) @(negedge clk);
      chk("full_pop_level", 32'(level), 32'd3);
      @(negedge clk);
      chk("full_refill_level", 32'(level), 32'd4);
      in_valid = 1'b0;
      auto_ack = 1;
      ack_dly = 3;
      wait_idle(400, "full_idle");
      chk("full_count", 32'(seen.size() - base), 32'd6);
      for (int i = 0; i < 6; i++)
         if (base + i < seen.size())
            chk("full_order", 32'(seen[base+i]), 32'(exp3[i]));

      // reset while REQ_HI with rack high
      auto_ack = 0;
      man_rack = 1'b0;
      @(negedge clk);
      push(8'h5A, st);
      wait_rreq(1'b1, 20, "rst_rreq_rise");
      push(8'h5B, st);
      man_rack = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rreq", 32'(rreq), 32'd0);
      chk("midrst_level", 32'(level), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(8'h66, st);
      for (int i = 0; i < 10; i++) begin
         chk("stale_ack_rreq", 32'(rreq), 32'd0);
         @(negedge clk);
      end
      man_rack = 1'b0;
      wait_rreq(1'b1, 20, "after_stale_rise");
      chk("after_stale_rdata", 32'(rdata), 32'h66);
      auto_ack = 1;
      wait_idle(100, "after_stale_idle");

      // spurious rack pulse while idle and empty
      auto_ack = 0;
      man_rack = 1'b0;
      @(negedge clk);
      man_rack = 1'b1;
      repeat (3) @(negedge clk);
      man_rack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("spur_rreq", 32'(rreq), 32'd0);
         chk("spur_busy", 32'(busy), 32'd0);
         @(negedge clk);
      end

`ifdef BD4_TX_ACK_TIMEOUT_EN
      // ack never arrives
      push(8'h3C, st);
      wait_rreq(1'b1, 20, "to_rreq_rise");
      repeat (15) @(negedge clk);
      chk("to_err_early", 32'(timeout_err), 32'd0);
      chk("to_rreq_early", 32'(rreq), 32'd1);
      @(negedge clk);
      chk("to_err_set", 32'(timeout_err), 32'd1);
      chk("to_rreq_forced", 32'(rreq), 32'd0);
      repeat (5) @(negedge clk);
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("to_err_cleared", 32'(timeout_err), 32'd0);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
